// File: rtl/pixel_compositor.sv
// Priority pixel compositor with two-stage pipeline and blanking.
// Define COMPOSITOR_NIGHT_EN to build in the day/night fade engine.
module pixel_compositor #(
    parameter int LAYERS      = 4,
    parameter int SCREEN_W    = 640,
    parameter int SCREEN_H    = 480,
    parameter int FADE_FRAMES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pix_en,
    input  logic [9:0]        vga_x,
    input  logic [9:0]        vga_y,
    input  logic [LAYERS-1:0] layer_grey,
    input  logic [LAYERS-1:0] layer_white,
    input  logic              frame_start,
    input  logic              night_req,
    output logic [2:0]        vgaRed,
    output logic [2:0]        vgaGreen,
    output logic [1:0]        vgaBlue,
    output logic              night_active
);

    localparam logic [10:0] W_LIM = SCREEN_W[10:0];
    localparam logic [10:0] H_LIM = SCREEN_H[10:0];

    typedef enum logic [1:0] {
        CLS_BLANK,
        CLS_BG,
        CLS_GREY,
        CLS_WHITE
    } cls_t;

    cls_t       cls1_q, cls1_d, cls_hit;
    logic [7:0] rgb_q, rgb_d;
    logic [2:0] lvl;
    logic [2:0] inv;
    logic       vis;

    // Walk from lowest priority upward so layer 0 is written last and wins.
    always_comb begin
        vis = ({1'b0, vga_x} < W_LIM) && ({1'b0, vga_y} < H_LIM);
        cls_hit = CLS_BG;
        for (int i = LAYERS - 1; i >= 0; i--) begin
            if (layer_grey[i]) begin
                cls_hit = CLS_GREY;
            end else if (layer_white[i]) begin
                cls_hit = CLS_WHITE;
            end
        end
        cls1_d = cls1_q;
        if (pix_en) begin
            cls1_d = vis ? cls_hit : CLS_BLANK;
        end
    end

    always_comb begin
        inv   = ~lvl;
        rgb_d = rgb_q;
        if (pix_en) begin
            unique case (cls1_q)
                CLS_BLANK: rgb_d = 8'h00;
                CLS_BG:    rgb_d = {inv, inv, inv[2:1]};
                CLS_GREY:  rgb_d = {lvl, lvl, lvl[2:1]};
                default:   rgb_d = {3'd7, 3'd7, 2'd3};
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cls1_q <= CLS_BLANK;
            rgb_q  <= 8'h00;
        end else begin
            cls1_q <= cls1_d;
            rgb_q  <= rgb_d;
        end
    end

    assign vgaRed   = rgb_q[7:5];
    assign vgaGreen = rgb_q[4:2];
    assign vgaBlue  = rgb_q[1:0];

`ifdef COMPOSITOR_NIGHT_EN
    localparam int FCW = (FADE_FRAMES > 1) ? $clog2(FADE_FRAMES) : 1;
    localparam logic [FCW-1:0] FC_LAST = FCW'(FADE_FRAMES - 1);

    typedef enum logic [1:0] {
        DAY,
        TO_NIGHT,
        NIGHT,
        TO_DAY
    } fade_t;

    fade_t          state_q, state_d;
    logic [FCW-1:0] fc_q, fc_d, fc_base;
    logic [2:0]     lvl_q, lvl_d;
    logic           night_q, night_d;
    logic           step_up, step_dn;

    // A direction change restarts the step count; that frame is step frame one.
    always_comb begin
        state_d = state_q;
        fc_d    = fc_q;
        lvl_d   = lvl_q;
        fc_base = fc_q;
        step_up = 1'b0;
        step_dn = 1'b0;
        if (frame_start) begin
            unique case (state_q)
                DAY: begin
                    step_up = night_req;
                    fc_base = '0;
                end
                TO_NIGHT: begin
                    step_up = night_req;
                    step_dn = !night_req;
                    if (!night_req) fc_base = '0;
                end
                NIGHT: begin
                    step_dn = !night_req;
                    fc_base = '0;
                end
                default: begin
                    step_up = night_req;
                    step_dn = !night_req;
                    if (night_req) fc_base = '0;
                end
            endcase
        end
        if (step_up) begin
            if (lvl_q == 3'd7) begin
                state_d = NIGHT;
                fc_d    = '0;
            end else if (fc_base == FC_LAST) begin
                fc_d    = '0;
                lvl_d   = lvl_q + 3'd1;
                state_d = (lvl_d == 3'd7) ? NIGHT : TO_NIGHT;
            end else begin
                fc_d    = fc_base + 1'b1;
                state_d = TO_NIGHT;
            end
        end else if (step_dn) begin
            if (lvl_q == 3'd0) begin
                state_d = DAY;
                fc_d    = '0;
            end else if (fc_base == FC_LAST) begin
                fc_d    = '0;
                lvl_d   = lvl_q - 3'd1;
                state_d = (lvl_d == 3'd0) ? DAY : TO_DAY;
            end else begin
                fc_d    = fc_base + 1'b1;
                state_d = TO_DAY;
            end
        end
        night_d = (state_d == NIGHT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DAY;
            fc_q    <= '0;
            lvl_q   <= 3'd0;
            night_q <= 1'b0;
        end else begin
            state_q <= state_d;
            fc_q    <= fc_d;
            lvl_q   <= lvl_d;
            night_q <= night_d;
        end
    end

    assign lvl          = lvl_q;
    assign night_active = night_q;
`else
    logic unused_fade_in;

    assign unused_fade_in = &{1'b0, night_req, frame_start};
    assign lvl            = 3'd0;
    assign night_active   = 1'b0;
`endif

endmodule
